// File: rtl/seq_hit_display.sv
// -----------------------------------------------------------------------------
// seq_hit_display
//
// Counts rising edges of a sequence-detector flag (one hit per det_in level,
// no matter how long it is held) as a BCD digit 0..9 and drives a 7-segment
// display with it. The decimal point flags recent hits.
//
// Optional feature macro: HIT_STRETCH_EN
//   defined   : dp is held for STRETCH_CYCLES clocks after each hit; a new hit
//               restarts the hold time.
//   undefined : dp is a single-cycle pulse alongside each digit update.
//
// Ports
//   clk       in   single clock, all state changes on its rising edge
//   rst       in   synchronous active-high reset
//   ena       in   hit-counting enable
//   det_in    in   detection flag from the sequence detector (level or pulse)
//   clr       in   synchronous clear of count, ovf and stretch timer
//   seg_out   out  [7:0] registered segments, bit0=a .. bit6=g, bit7=dp
//   count_out out  [3:0] registered BCD hit count
//   ovf       out  sticky flag, set on a 9->0 wrap
// -----------------------------------------------------------------------------
module seq_hit_display #(
    parameter logic [15:0] STRETCH_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       det_in,
    input  logic       clr,
    output logic [7:0] seg_out,
    output logic [3:0] count_out,
    output logic       ovf
);

    logic       det_q, det_d;
    logic [3:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic [7:0] seg_q, seg_d;
    logic       hit;
    logic       dp;

`ifdef HIT_STRETCH_EN
    logic [15:0] timer_q, timer_d;
`else
    logic        hit_q, hit_d;
`endif

    // Active-high segments a..g; out-of-range codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        det_d   = det_in;
        count_d = count_q;
        ovf_d   = ovf_q;

        // det_q tracks det_in even while disabled, so a level already high
        // when ena rises is never seen as an edge.
        hit = det_in & ~det_q & ena;

        if (clr) begin
            count_d = 4'd0;
            ovf_d   = 1'b0;
        end else if (hit) begin
            if (count_q == 4'd9) begin
                count_d = 4'd0;
                ovf_d   = 1'b1;
            end else if (count_q > 4'd9) begin
                // Recovery from an illegal code: restart without flagging a wrap.
                count_d = 4'd0;
            end else begin
                count_d = count_q + 4'd1;
            end
        end

`ifdef HIT_STRETCH_EN
        // The timer runs down regardless of ena; clr wins over a reload.
        timer_d = timer_q;
        if (clr) begin
            timer_d = 16'd0;
        end else if (hit) begin
            timer_d = STRETCH_CYCLES;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end
        // timer_q is loaded on the hit edge, so dp rises on the following edge
        // together with the new digit and stays up for STRETCH_CYCLES clocks.
        dp = (timer_q != 16'd0);
`else
        hit_d = hit & ~clr;
        dp    = hit_q;
`endif

        // Segments decode the already-registered count: one more edge of latency.
        seg_d = {dp, decode(count_q)};
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            det_q   <= 1'b0;
            count_q <= 4'd0;
            ovf_q   <= 1'b0;
            seg_q   <= 8'h3F;
`ifdef HIT_STRETCH_EN
            timer_q <= 16'd0;
`else
            hit_q   <= 1'b0;
`endif
        end else begin
            det_q   <= det_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            seg_q   <= seg_d;
`ifdef HIT_STRETCH_EN
            timer_q <= timer_d;
`else
            hit_q   <= hit_d;
`endif
        end
    end

    assign seg_out   = seg_q;
    assign count_out = count_q;
    assign ovf       = ovf_q;

endmodule
